// File: rtl/mux_nx1_pipe_if.sv
// Handshake bundle for the N:1 pipelined select: upstream offer side and downstream head side.
interface mux_nx1_pipe_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4
);
    localparam int SEL_W = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]   in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_err;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_err, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_err, out_valid
    );
endinterface

// File: rtl/mux_nx1_pipe.sv
// N:1 word select captured into a 2-entry head/skid buffer with valid/ready output.
// Latency 1 cycle; in_ready is registered and falls only when both entries are full.
// Flush empties the buffer with priority over accept and pop.
module mux_nx1_pipe #(
    parameter int WIDTH = 32,
    parameter int N     = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    mux_nx1_pipe_if.slave  bus
);
    localparam int SEL_W = $clog2(N);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             ready_q;
    logic             accept;
    logic             pop;
    logic             load_head;
    logic             load_skid;
    logic             skid_to_head;

    logic [WIDTH-1:0] word;
    logic             err;
    logic [WIDTH-1:0] head_data;
    logic [SEL_W-1:0] head_sel;
    logic             head_err;
    logic [WIDTH-1:0] skid_data;
    logic [SEL_W-1:0] skid_sel;
    logic             skid_err;

    // Out-of-range selects fall back to slice 0 and raise err.
    always_comb begin
        word = bus.in_data[WIDTH-1:0];
        err  = (32'(bus.in_sel) >= 32'(N));
        for (int i = 0; i < N; i++) begin
            if (bus.in_sel == SEL_W'(i)) begin
                word = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign accept = bus.in_valid & ready_q;
    assign pop    = (state != EMPTY) & bus.out_ready;

    always_comb begin
        state_nxt    = state;
        load_head    = 1'b0;
        load_skid    = 1'b0;
        skid_to_head = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt = ONE;
                        load_head = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        state_nxt = TWO;
                        load_skid = 1'b1;
                    end else if (accept && pop) begin
                        load_head = 1'b1;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_nxt    = ONE;
                        skid_to_head = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            ready_q   <= 1'b0;
            head_data <= '0;
            head_sel  <= '0;
            head_err  <= 1'b0;
            skid_data <= '0;
            skid_sel  <= '0;
            skid_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != TWO);
            if (load_head) begin
                head_data <= word;
                head_sel  <= bus.in_sel;
                head_err  <= err;
            end else if (skid_to_head) begin
                head_data <= skid_data;
                head_sel  <= skid_sel;
                head_err  <= skid_err;
            end
            if (load_skid) begin
                skid_data <= word;
                skid_sel  <= bus.in_sel;
                skid_err  <= err;
            end
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = (state != EMPTY);
    assign bus.out_data  = head_data;
    assign bus.out_sel   = head_sel;
    assign bus.out_err   = head_err;
endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Scoreboard bench for mux_nx1_pipe: a 32-bit/4-input instance and an 8-bit/5-input instance.
module tb_mux_nx1_pipe;
    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic flush_a = 1'b0;
    logic flush_b = 1'b0;
    int   checks  = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mux_nx1_pipe_if #(.WIDTH(32), .N(4)) bus_a();
    mux_nx1_pipe_if #(.WIDTH(8),  .N(5)) bus_b();

    mux_nx1_pipe #(.WIDTH(32), .N(4)) dut_a (.clk(clk), .rst_n(rst_n), .flush(flush_a), .bus(bus_a));
    mux_nx1_pipe #(.WIDTH(8),  .N(5)) dut_b (.clk(clk), .rst_n(rst_n), .flush(flush_b), .bus(bus_b));

    typedef struct packed { logic [31:0] d; logic [1:0] s; logic e; } ent_a_t;
    typedef struct packed { logic [7:0]  d; logic [2:0] s; logic e; } ent_b_t;

    ent_a_t qa[$];
    ent_b_t qb[$];
    logic   rdy_a_exp = 1'b0;
    logic   rdy_b_exp = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_a_t sel_a(input logic [127:0] din, input logic [1:0] s);
        ent_a_t r;
        r.d = din[s*32 +: 32];
        r.s = s;
        r.e = 1'b0;
        return r;
    endfunction

    function automatic ent_b_t sel_b(input logic [39:0] din, input logic [2:0] s);
        ent_b_t r;
        r.e = (s >= 3'd5);
        r.d = r.e ? din[7:0] : din[s*8 +: 8];
        r.s = s;
        return r;
    endfunction

    always @(negedge clk) begin
        logic acc;
        logic pop;
        if (!rst_n) begin
            qa.delete();
            rdy_a_exp = 1'b0;
        end else begin
            check_eq("a_in_ready", bus_a.in_ready, rdy_a_exp);
            check_eq("a_out_valid", bus_a.out_valid, qa.size() != 0);
            if (qa.size() != 0) begin
                check_eq("a_out_data", bus_a.out_data, qa[0].d);
                check_eq("a_out_sel", bus_a.out_sel, qa[0].s);
                check_eq("a_out_err", bus_a.out_err, qa[0].e);
            end
            acc = bus_a.in_valid && rdy_a_exp;
            pop = (qa.size() != 0) && bus_a.out_ready;
            if (flush_a) qa.delete();
            else begin
                if (pop) void'(qa.pop_front());
                if (acc) qa.push_back(sel_a(bus_a.in_data, bus_a.in_sel));
            end
            rdy_a_exp = (qa.size() < 2);
        end
    end

    always @(negedge clk) begin
        logic acc;
        logic pop;
        if (!rst_n) begin
            qb.delete();
            rdy_b_exp = 1'b0;
        end else begin
            check_eq("b_in_ready", bus_b.in_ready, rdy_b_exp);
            check_eq("b_out_valid", bus_b.out_valid, qb.size() != 0);
            if (qb.size() != 0) begin
                check_eq("b_out_data", bus_b.out_data, qb[0].d);
                check_eq("b_out_sel", bus_b.out_sel, qb[0].s);
                check_eq("b_out_err", bus_b.out_err, qb[0].e);
            end
            acc = bus_b.in_valid && rdy_b_exp;
            pop = (qb.size() != 0) && bus_b.out_ready;
            if (flush_b) qb.delete();
            else begin
                if (pop) void'(qb.pop_front());
                if (acc) qb.push_back(sel_b(bus_b.in_data, bus_b.in_sel));
            end
            rdy_b_exp = (qb.size() < 2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the offer until the DUT takes it, bounded by a cycle budget.
    task automatic offer_a(input logic [1:0] s, input logic rdy);
        bus_a.in_valid  = 1'b1;
        bus_a.in_sel    = s;
        bus_a.out_ready = rdy;
        for (int i = 0; i < 20; i++) begin
            logic took;
            took = bus_a.in_ready;
            tick();
            if (took) begin
                bus_a.in_valid = 1'b0;
                return;
            end
        end
        check_eq("a_offer_timeout", bus_a.in_ready, 1'b1);
        bus_a.in_valid = 1'b0;
    endtask

    task automatic offer_b(input logic [2:0] s);
        bus_b.in_valid = 1'b1;
        bus_b.in_sel   = s;
        for (int i = 0; i < 20; i++) begin
            logic took;
            took = bus_b.in_ready;
            tick();
            if (took) begin
                bus_b.in_valid = 1'b0;
                return;
            end
        end
        check_eq("b_offer_timeout", bus_b.in_ready, 1'b1);
        bus_b.in_valid = 1'b0;
    endtask

    task automatic idle_a(input int n, input logic rdy);
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = rdy;
        repeat (n) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] da [4];
        da[0] = 32'hAAAA0000; da[1] = 32'hBBBB0001; da[2] = 32'hCCCC0002; da[3] = 32'hDDDD0003;
        bus_a.in_data   = {da[3], da[2], da[1], da[0]};
        bus_a.in_sel    = '0;
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b1;
        bus_b.in_data   = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
        bus_b.in_sel    = '0;
        bus_b.in_valid  = 1'b0;
        bus_b.out_ready = 1'b1;

        repeat (2) tick();
        check_eq("rst_out_valid", bus_a.out_valid, 1'b0);
        check_eq("rst_out_data", bus_a.out_data, 32'h0);
        check_eq("rst_in_ready", bus_a.in_ready, 1'b0);
        rst_n = 1'b1;
        tick();
        check_eq("rel_in_ready", bus_a.in_ready, 1'b1);

        // Streaming at full rate.
        for (int k = 0; k < 4; k++) begin
            offer_a(2'(k), 1'b1);
            check_eq("stream_data", bus_a.out_data, da[k]);
            check_eq("stream_ready", bus_a.in_ready, 1'b1);
        end
        idle_a(3, 1'b1);

        // Back-pressure fills both entries, then drains in order.
        offer_a(2'd2, 1'b0);
        offer_a(2'd1, 1'b0);
        bus_a.in_valid = 1'b1;
        bus_a.in_sel   = 2'd3;
        repeat (2) begin
            check_eq("bp_in_ready", bus_a.in_ready, 1'b0);
            check_eq("bp_hold_data", bus_a.out_data, 32'hCCCC0002);
            tick();
        end
        offer_a(2'd3, 1'b1);
        idle_a(4, 1'b1);

        // Accept and pop together in ONE.
        offer_a(2'd0, 1'b1);
        offer_a(2'd1, 1'b1);
        check_eq("ap_out_valid", bus_a.out_valid, 1'b1);
        check_eq("ap_out_data", bus_a.out_data, 32'hBBBB0001);
        check_eq("ap_in_ready", bus_a.in_ready, 1'b1);
        idle_a(3, 1'b1);

        // Flush in TWO with a simultaneous offer.
        offer_a(2'd2, 1'b0);
        offer_a(2'd3, 1'b0);
        bus_a.in_valid = 1'b1;
        bus_a.in_sel   = 2'd1;
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        bus_a.in_valid = 1'b0;
        check_eq("fl_out_valid", bus_a.out_valid, 1'b0);
        check_eq("fl_in_ready", bus_a.in_ready, 1'b1);
        idle_a(3, 1'b1);
        offer_a(2'd0, 1'b1);
        idle_a(2, 1'b1);

        // Out-of-range select on the 5-input instance.
        offer_b(3'd6);
        check_eq("oor_data", bus_b.out_data, 8'h10);
        check_eq("oor_sel", bus_b.out_sel, 3'd6);
        check_eq("oor_err", bus_b.out_err, 1'b1);
        offer_b(3'd4);
        check_eq("inr_data", bus_b.out_data, 8'h14);
        check_eq("inr_err", bus_b.out_err, 1'b0);
        offer_b(3'd7);
        offer_b(3'd5);
        offer_b(3'd2);
        repeat (3) tick();

        // Asynchronous reset while full.
        offer_a(2'd1, 1'b0);
        offer_a(2'd2, 1'b0);
        check_eq("ar_pre_valid", bus_a.out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_out_valid", bus_a.out_valid, 1'b0);
        check_eq("ar_out_data", bus_a.out_data, 32'h0);
        check_eq("ar_out_sel", bus_a.out_sel, 2'd0);
        check_eq("ar_out_err", bus_a.out_err, 1'b0);
        check_eq("ar_in_ready", bus_a.in_ready, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        bus_a.out_ready = 1'b1;
        tick();
        check_eq("ar_rel_ready", bus_a.in_ready, 1'b1);
        check_eq("ar_rel_valid", bus_a.out_valid, 1'b0);
        idle_a(3, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
